// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the rotating HEX display: glyph codes, FSM states
// and the four-entry message ROM.
package hex_scroll_pkg;

  // Number of seven-segment digits driven by the controller.
  localparam int unsigned NUM_DIGITS = 6;

  // Glyph codes held in the code register array.
  localparam logic [3:0] GLYPH_BLANK = 4'h0;
  localparam logic [3:0] GLYPH_ONE   = 4'h1;
  localparam logic [3:0] GLYPH_D     = 4'h2;
  localparam logic [3:0] GLYPH_E     = 4'h3;
  localparam logic [3:0] GLYPH_H     = 4'h4;
  localparam logic [3:0] GLYPH_L     = 4'h5;
  localparam logic [3:0] GLYPH_O     = 4'h6;
  localparam logic [3:0] GLYPH_C     = 4'h7;
  localparam logic [3:0] GLYPH_DASH  = 4'h8;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ONE  = 7'h79;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_H    = 7'h09;
  localparam logic [6:0] SEG_L    = 7'h47;
  localparam logic [6:0] SEG_O    = 7'h40;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Sequencer states.
  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  // Message ROM; pos 0 is the rightmost digit (HEX0), pos 5 the leftmost.
  function automatic logic [3:0] msg_rom(input logic [1:0] idx, input logic [2:0] pos);
    logic [23:0] w_msg;  // packed {c5,c4,c3,c2,c1,c0}
    logic [23:0] w_sh;
    unique case (idx)
      2'd0: w_msg = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_D, GLYPH_E, GLYPH_ONE};
      2'd1: w_msg = {GLYPH_H, GLYPH_E, GLYPH_L, GLYPH_L, GLYPH_O, GLYPH_BLANK};
      2'd2: w_msg = {GLYPH_C, GLYPH_O, GLYPH_D, GLYPH_E, GLYPH_BLANK, GLYPH_BLANK};
      default: w_msg = {GLYPH_D, GLYPH_E, GLYPH_D, GLYPH_E, GLYPH_D, GLYPH_E};
    endcase
    w_sh = w_msg >> {pos, 2'b00};
    if (pos > 3'd5) begin
      return GLYPH_BLANK;
    end
    return w_sh[3:0];
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_dec.sv
// Glyph code to active-low seven-segment decoder.
module hex_glyph_dec
  import hex_scroll_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Pure lookup; any code outside the glyph set blanks the digit.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      GLYPH_BLANK: o_seg = SEG_OFF;
      GLYPH_ONE:   o_seg = SEG_ONE;
      GLYPH_D:     o_seg = SEG_D;
      GLYPH_E:     o_seg = SEG_E;
      GLYPH_H:     o_seg = SEG_H;
      GLYPH_L:     o_seg = SEG_L;
      GLYPH_O:     o_seg = SEG_O;
      GLYPH_C:     o_seg = SEG_C;
      GLYPH_DASH:  o_seg = SEG_DASH;
      default:     o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Six-digit rotating HEX display sequencer: input synchronizers, tick counter,
// load/run/pause FSM and the rotating glyph code registers.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 12_500_000,
  parameter int unsigned CNT_W      = 27
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  input  logic [4:0] SW,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [9:0] LEDR
);

  logic             w_rst_n;
  logic [4:0]       r_sw_s1;
  logic [4:0]       r_sw_s2;
  logic             r_key_s1;
  logic             r_key_s2;
  logic             r_key_s3;
  logic [1:0]       r_spd_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_last;
  logic [1:0]       r_msg_idx;
  logic [3:0]       r_codes [NUM_DIGITS];
  state_e           r_state;
  state_e           w_state_nxt;

  logic w_press;
  logic w_spd_chg;
  logic w_msg_chg;
  logic w_tick;
  logic w_load;
  logic w_run;
  logic w_paused;

  // KEY[0] is a direct synchronous reset; it is deliberately not synchronized.
  assign w_rst_n = KEY[0];

  // Two-flop synchronizers for the switches and the pause key, plus one extra
  // key stage for falling-edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_key_s1   <= 1'b1;
      r_key_s2   <= 1'b1;
      r_key_s3   <= 1'b1;
      r_spd_prev <= '0;
    end else begin
      r_sw_s1    <= SW;
      r_sw_s2    <= r_sw_s1;
      r_key_s1   <= KEY[1];
      r_key_s2   <= r_key_s1;
      r_key_s3   <= r_key_s2;
      r_spd_prev <= r_sw_s2[1:0];
    end
  end

  assign w_press   = r_key_s3 & ~r_key_s2;
  assign w_spd_chg = (r_sw_s2[1:0] != r_spd_prev);
  assign w_msg_chg = (r_sw_s2[4:3] != r_msg_idx);

  // Terminal count for the currently selected speed.
  always_comb begin
    w_cnt_last = '0;
    unique case (r_sw_s2[1:0])
      2'b00: w_cnt_last = CNT_W'(4 * BASE_TICKS - 1);
      2'b01: w_cnt_last = CNT_W'(2 * BASE_TICKS - 1);
      2'b10: w_cnt_last = CNT_W'(BASE_TICKS - 1);
      default: w_cnt_last = CNT_W'(8 * BASE_TICKS - 1);
    endcase
  end

  // A tick only rotates when no higher-priority event claims the cycle.
  assign w_tick = w_run & ~w_msg_chg & ~w_press & ~w_spd_chg & (r_cnt == w_cnt_last);

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: message change beats a press.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StLoad: w_state_nxt = StRun;
      StRun: begin
        if (w_msg_chg) begin
          w_state_nxt = StLoad;
        end else if (w_press) begin
          w_state_nxt = StPaused;
        end
      end
      StPaused: begin
        if (w_msg_chg) begin
          w_state_nxt = StLoad;
        end else if (w_press) begin
          w_state_nxt = StRun;
        end
      end
      default: w_state_nxt = StLoad;
    endcase
  end

  // FSM state decode.
  always_comb begin
    w_load   = (r_state == StLoad);
    w_run    = (r_state == StRun);
    w_paused = (r_state == StPaused);
  end

  // Tick counter: held while paused or on a press, cleared on speed change.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_msg_chg) begin
      r_cnt <= r_cnt;
    end else if (w_spd_chg) begin
      r_cnt <= '0;
    end else if (w_run && !w_press) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  // Loaded message index, shown on LEDR[9:8].
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_msg_idx <= '0;
    end else if (w_load) begin
      r_msg_idx <= r_sw_s2[4:3];
    end
  end

  // Glyph code array: loaded from ROM, rotated as a pure permutation on tick.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_codes[i] <= GLYPH_BLANK;
      end
    end else if (w_load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_codes[i] <= msg_rom(r_sw_s2[4:3], 3'(i));
      end
    end else if (w_tick) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!r_sw_s2[2]) begin
          r_codes[i] <= r_codes[(i + NUM_DIGITS - 1) % NUM_DIGITS];
        end else begin
          r_codes[i] <= r_codes[(i + 1) % NUM_DIGITS];
        end
      end
    end
  end

  // Status LEDs.
  always_comb begin
    LEDR      = '0;
    LEDR[0]   = w_paused;
    LEDR[1]   = r_sw_s2[2];
    LEDR[9:8] = r_msg_idx;
  end

  hex_glyph_dec u_dec5 (.i_code(r_codes[5]), .o_seg(HEX5));
  hex_glyph_dec u_dec4 (.i_code(r_codes[4]), .o_seg(HEX4));
  hex_glyph_dec u_dec3 (.i_code(r_codes[3]), .o_seg(HEX3));
  hex_glyph_dec u_dec2 (.i_code(r_codes[2]), .o_seg(HEX2));
  hex_glyph_dec u_dec1 (.i_code(r_codes[1]), .o_seg(HEX1));
  hex_glyph_dec u_dec0 (.i_code(r_codes[0]), .o_seg(HEX0));

endmodule
